load_align_unit: RTL and testbench

- Parametrised writeback-stage load data aligner; successor to the fixed 32-bit load extender.
- Takes raw memory beats from the data cache and produces the architectural load result: byte/half/word/dword extraction, sign/zero extension, and LWL/LWR merge with the old rt value.
- Differs from the fixed extender: it is width-generic and handshaked (valid/ready), and it can merge two beats for loads that cross a DATA_W boundary.

---
 rtl/load_align_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_load_align_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Writeback-stage load aligner: extracts, extends and merges raw memory beats into the
// architectural load result, taking a second beat for loads that cross a beat boundary.
module load_align_unit #(
    parameter int DATA_W         = 32,
    parameter int ALLOW_MISALIGN = 1,
    parameter int OFF_W          = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_type,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_rt,
    output logic              need_beat2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_adel
);
    localparam int NB = DATA_W / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT2 = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [3:0] T_LB  = 4'd0;
    localparam logic [3:0] T_LBU = 4'd1;
    localparam logic [3:0] T_LH  = 4'd2;
    localparam logic [3:0] T_LHU = 4'd3;
    localparam logic [3:0] T_LW  = 4'd4;
    localparam logic [3:0] T_LWU = 4'd5;
    localparam logic [3:0] T_LD  = 4'd6;
    localparam logic [3:0] T_LWL = 4'd7;
    localparam logic [3:0] T_LWR = 4'd8;

    function automatic logic [3:0] load_size(input logic [3:0] t);
        logic [3:0] s;
        case (t)
            T_LB, T_LBU: s = 4'd1;
            T_LH, T_LHU: s = 4'd2;
            T_LD:        s = 4'd8;
            default:     s = 4'd4;
        endcase
        return s;
    endfunction

    function automatic logic is_illegal(input logic [3:0] t);
        return (t > T_LWR) || ((DATA_W == 32) && ((t == T_LWU) || (t == T_LD)));
    endfunction

    function automatic logic is_merge(input logic [3:0] t);
        return (t == T_LWL) || (t == T_LWR);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] t, input logic [OFF_W-1:0] off);
        logic [3:0] off4;
        off4 = 4'(off);
        return (off4 & (load_size(t) - 4'd1)) != 4'd0;
    endfunction

    function automatic logic is_crossing(input logic [3:0] t, input logic [OFF_W-1:0] off);
        return ({1'b0, 4'(off)} + {1'b0, load_size(t)}) > 5'(NB);
    endfunction

    function automatic logic is_split(input logic [3:0] t, input logic [OFF_W-1:0] off);
        return (ALLOW_MISALIGN != 0) && !is_illegal(t) && !is_merge(t)
            && is_misaligned(t, off) && is_crossing(t, off);
    endfunction

    function automatic logic raise_adel(input logic [3:0] t, input logic [OFF_W-1:0] off);
        return is_illegal(t) || (!is_merge(t) && (ALLOW_MISALIGN == 0) && is_misaligned(t, off));
    endfunction

    // LWL/LWR work on the 32-bit word holding the addressed byte; the merge is sign-extended.
    function automatic logic [DATA_W-1:0] merge_word(input logic [3:0] t, input logic [OFF_W-1:0] off,
                                                     input logic [DATA_W-1:0] beat, input logic [31:0] rt);
        logic [OFF_W-1:0]  word_off;
        logic [DATA_W-1:0] shifted;
        logic [31:0]       word;
        logic [31:0]       merged;
        word_off = off & ~OFF_W'(2'd3);
        shifted  = beat >> {word_off, 3'b000};
        word     = shifted[31:0];
        if (t == T_LWL) begin
            case (off[1:0])
                2'd0:    merged = {word[7:0], rt[23:0]};
                2'd1:    merged = {word[15:0], rt[15:0]};
                2'd2:    merged = {word[23:0], rt[7:0]};
                default: merged = word;
            endcase
        end else begin
            case (off[1:0])
                2'd0:    merged = word;
                2'd1:    merged = {rt[31:24], word[31:8]};
                2'd2:    merged = {rt[31:16], word[31:16]};
                default: merged = {rt[31:8], word[31:24]};
            endcase
        end
        return DATA_W'($signed(merged));
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [3:0] t, input logic [OFF_W-1:0] off,
                                                  input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] b2);
        logic [2*DATA_W-1:0] wide;
        logic [DATA_W-1:0]   value;
        wide = {b2, b1} >> {off, 3'b000};
        case (t)
            T_LB:    value = DATA_W'($signed(wide[7:0]));
            T_LBU:   value = DATA_W'(wide[7:0]);
            T_LH:    value = DATA_W'($signed(wide[15:0]));
            T_LHU:   value = DATA_W'(wide[15:0]);
            T_LW:    value = DATA_W'($signed(wide[31:0]));
            T_LWU:   value = DATA_W'(wide[31:0]);
            T_LD:    value = wide[DATA_W-1:0];
            default: value = {DATA_W{1'b0}};
        endcase
        return value;
    endfunction

    // Result is {adel, data}; data is forced to zero when the address error is raised.
    function automatic logic [DATA_W:0] load_result(input logic [3:0] t, input logic [OFF_W-1:0] off,
                                                    input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] b2,
                                                    input logic [31:0] rt);
        logic              adel;
        logic [DATA_W-1:0] data;
        adel = raise_adel(t, off);
        if (adel) begin
            data = {DATA_W{1'b0}};
        end else if (is_merge(t)) begin
            data = merge_word(t, off, b1, rt);
        end else begin
            data = extract(t, off, b1, b2);
        end
        return {adel, data};
    endfunction

    logic [1:0]        state_r;
    logic [3:0]        type_r;
    logic [OFF_W-1:0]  off_r;
    logic [DATA_W-1:0] beat1_r;
    logic [31:0]       rt_r;
    logic              out_valid_r;
    logic              out_adel_r;
    logic [DATA_W-1:0] out_data_r;

    logic [1:0]        state_n_s;
    logic              valid_n_s;
    logic              adel_n_s;
    logic [DATA_W-1:0] data_n_s;
    logic              capture_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              first_split_s;
    logic [DATA_W:0]   first_res_s;
    logic [DATA_W:0]   second_res_s;

    assign accept_s      = in_valid && in_ready_s;
    assign first_split_s = is_split(in_type, in_off);
    assign first_res_s   = load_result(in_type, in_off, in_data, {DATA_W{1'b0}}, in_rt[31:0]);
    assign second_res_s  = load_result(type_r, off_r, beat1_r, in_data, rt_r);

    // FULL only takes a new beat when the held result leaves in the same cycle.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_WAIT2: in_ready_s = 1'b1;
            ST_FULL:           in_ready_s = out_ready;
            default:           in_ready_s = 1'b0;
        endcase
    end

    // Next-state and next-result selection.
    always_comb begin
        state_n_s = state_r;
        valid_n_s = out_valid_r;
        adel_n_s  = out_adel_r;
        data_n_s  = out_data_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_FULL: begin
                if (accept_s && first_split_s) begin
                    state_n_s = ST_WAIT2;
                    valid_n_s = 1'b0;
                    capture_s = 1'b1;
                end else if (accept_s) begin
                    state_n_s = ST_FULL;
                    valid_n_s = 1'b1;
                    adel_n_s  = first_res_s[DATA_W];
                    data_n_s  = first_res_s[DATA_W-1:0];
                end else if (out_ready) begin
                    state_n_s = ST_IDLE;
                    valid_n_s = 1'b0;
                end else begin
                    state_n_s = state_r;
                end
            end
            ST_WAIT2: begin
                if (accept_s) begin
                    state_n_s = ST_FULL;
                    valid_n_s = 1'b1;
                    adel_n_s  = second_res_s[DATA_W];
                    data_n_s  = second_res_s[DATA_W-1:0];
                end else begin
                    state_n_s = ST_WAIT2;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                valid_n_s = 1'b0;
            end
        endcase
    end

    // Control state and registered result.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_adel_r  <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_n_s;
            out_valid_r <= valid_n_s;
            out_adel_r  <= adel_n_s;
            out_data_r  <= data_n_s;
        end
    end

    // First beat of a split load, with the attributes that govern the merge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            type_r  <= 4'd0;
            off_r   <= {OFF_W{1'b0}};
            beat1_r <= {DATA_W{1'b0}};
            rt_r    <= 32'd0;
        end else if (capture_s) begin
            type_r  <= in_type;
            off_r   <= in_off;
            beat1_r <= in_data;
            rt_r    <= in_rt[31:0];
        end
    end

    assign in_ready   = in_ready_s;
    assign need_beat2 = (state_r == ST_WAIT2);
    assign out_valid  = out_valid_r;
    assign out_adel   = out_adel_r;
    assign out_data   = out_data_r;
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three configurations (32/misalign, 32/strict, 64/misalign)
// checked against a byte-level load model plus hand-computed literal results.
module tb_load_align_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, out_ready;
    logic [2:0]  vi;
    logic [3:0]  in_type;
    logic [2:0]  in_off;
    logic [63:0] in_data, in_rt;
    logic        rdy0, rdy1, rdy2, nb0, nb1, nb2_2, ov0, ov1, ov2, ad0, ad1, ad2;
    logic [31:0] od0, od1;
    logic [63:0] od2;
    logic [2:0]  rdy, nb2, ov, adl;
    assign rdy = {rdy2, rdy1, rdy0};
    assign nb2 = {nb2_2, nb1, nb0};
    assign ov  = {ov2, ov1, ov0};
    assign adl = {ad2, ad1, ad0};

    load_align_unit #(.DATA_W(32), .ALLOW_MISALIGN(1)) u_a32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(vi[0]), .in_ready(rdy0),
        .in_type(in_type), .in_off(in_off[1:0]), .in_data(in_data[31:0]), .in_rt(in_rt[31:0]),
        .need_beat2(nb0), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_adel(ad0));
    load_align_unit #(.DATA_W(32), .ALLOW_MISALIGN(0)) u_s32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(vi[1]), .in_ready(rdy1),
        .in_type(in_type), .in_off(in_off[1:0]), .in_data(in_data[31:0]), .in_rt(in_rt[31:0]),
        .need_beat2(nb1), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_adel(ad1));
    load_align_unit #(.DATA_W(64), .ALLOW_MISALIGN(1)) u_a64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(vi[2]), .in_ready(rdy2),
        .in_type(in_type), .in_off(in_off), .in_data(in_data), .in_rt(in_rt),
        .need_beat2(nb2_2), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_adel(ad2));

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] q0[$], q1[$], q2[$];
    logic [64:0] got;
    logic [63:0] pat [4] = '{64'h8192_A3B4_C5D6_E7F8, 64'h0F1E_2D3C_4B5A_6978,
                             64'hFEDC_BA98_7654_3210, 64'h7F80_01FE_8877_6655};

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] odk(input int k);
        case (k)
            0:       return {32'd0, od0};
            1:       return {32'd0, od1};
            default: return od2;
        endcase
    endfunction

    function automatic int size_of(input int t);
        return (t < 2) ? 1 : (t < 4) ? 2 : (t == 6) ? 8 : 4;
    endfunction

    function automatic bit model_split(input int k, input int t, input int off);
        int nb;
        nb = (k == 2) ? 8 : 4;
        if (k == 1 || t > 8 || t == 7 || t == 8 || (nb == 4 && (t == 5 || t == 6))) return 1'b0;
        return (off + size_of(t)) > nb;
    endfunction

    // Byte-addressed view of the load: lay out the beats as memory and read S bytes.
    function automatic logic [64:0] model(input int k, input int t, input int off,
                                          input logic [63:0] b1, input logic [63:0] b2, input logic [63:0] rt);
        int nb, s, b, base;
        bit allow, split;
        byte unsigned mem [16];
        longint unsigned v, w, r32;
        nb    = (k == 2) ? 8 : 4;
        allow = (k != 1);
        if (t > 8 || (nb == 4 && (t == 5 || t == 6))) return {1'b1, 64'd0};
        split = model_split(k, t, off);
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        for (int i = 0; i < nb; i++) begin
            mem[i] = b1[8*i +: 8];
            if (split) mem[nb+i] = b2[8*i +: 8];
        end
        if (t == 7 || t == 8) begin
            base = (off / 4) * 4;
            b    = off % 4;
            w    = 64'd0;
            for (int i = 0; i < 4; i++) w = w | (longint'(mem[base+i]) << (8*i));
            r32 = {32'd0, rt[31:0]};
            if (t == 7) v = ((w << (8*(3-b))) | (r32 & ((64'd1 << (8*(3-b))) - 64'd1))) & 64'hFFFF_FFFF;
            else        v = (w >> (8*b)) | ((r32 >> (32-8*b)) << (32-8*b));
            if (nb == 8 && (v & 64'h8000_0000) != 64'd0) v = v | 64'hFFFF_FFFF_0000_0000;
            return {1'b0, v};
        end
        s = size_of(t);
        if ((off % s) != 0 && !allow) return {1'b1, 64'd0};
        v = 64'd0;
        for (int i = 0; i < s; i++) v = v | (longint'(mem[off+i]) << (8*i));
        if ((t == 0 || t == 2 || t == 4) && ((v >> (8*s-1)) & 64'd1) != 64'd0)
            v = v | ~((64'd1 << (8*s)) - 64'd1);
        if (nb == 4) v = v & 64'hFFFF_FFFF;
        return {1'b0, v};
    endfunction

    task automatic push(input int k, input logic [64:0] e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Present one beat to instance k and return just after the edge that accepts it.
    task automatic beat(input int k, input int t, input int off, input logic [63:0] d, input logic [63:0] rt);
        int n;
        n = 0;
        in_type = 4'(t); in_off = 3'(off); in_data = d; in_rt = rt; vi[k] = 1'b1;
        @(negedge clk);
        while (!rdy[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[k]) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: inst %0d in_ready 0, required 1", k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input int t, input int off, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] rt, output logic [64:0] res);
        push(k, model(k, t, off, b1, b2, rt));
        beat(k, t, off, b1, rt);
        if (model_split(k, t, off)) begin
            check("need_beat2_set", {64'd0, nb2[k]}, 65'd1);
            check("wait2_no_valid", {64'd0, ov[k]}, 65'd0);
            beat(k, 15, off ^ 1, b2, ~rt);
        end
        vi[k] = 1'b0;
        check("latency_valid", {64'd0, ov[k]}, 65'd1);
        res = {adl[k], odk(k)};
    endtask

    // Scoreboard: every handshaken result must match the model, and stalled results must hold.
    initial begin
        logic [2:0]  held_v;
        logic [64:0] held_d [3];
        logic [64:0] cur, e;
        bit          have;
        held_v = 3'b000;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 3'b000;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    cur = {adl[k], odk(k)};
                    if (held_v[k]) begin
                        check("stall_valid", {64'd0, ov[k]}, 65'd1);
                        check("stall_hold", cur, held_d[k]);
                    end
                    if (ov[k] && out_ready) begin
                        have = 1'b1;
                        e = 65'd0;
                        case (k)
                            0:       if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
                            1:       if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
                            default: if (q2.size() == 0) have = 1'b0; else e = q2.pop_front();
                        endcase
                        check("result_pending", {64'd0, have}, 65'd1);
                        if (have) check("result", cur, e);
                    end
                    held_v[k] = ov[k] && !out_ready && !flush;
                    held_d[k] = cur;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; vi = 3'b000;
        in_type = 4'd0; in_off = 3'd0; in_data = 64'd0; in_rt = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", {64'd0, ov[k]}, 65'd0);
            check("rst_data", {adl[k], odk(k)}, 65'd0);
            check("rst_need_beat2", {64'd0, nb2[k]}, 65'd0);
            check("rst_in_ready", {64'd0, rdy[k]}, 65'd1);
        end
        @(posedge clk);
        #1;

        check("model_lw_split", model(0, 4, 3, 64'h4433_2211, 64'h8877_6655, 64'd0), {1'b0, 64'h7766_5544});
        check("model_lwr_b0", model(0, 8, 0, 64'hAABB_CCDD, 64'd0, 64'h1122_3344), {1'b0, 64'hAABB_CCDD});
        check("model_lwl64", model(2, 7, 5, 64'hAABB_CCDD_0000_0000, 64'd0, 64'h1122_3344),
              {1'b0, 64'hFFFF_FFFF_CCDD_3344});
        check("model_lhu_contained", model(0, 3, 1, 64'h4433_2211, 64'd0, 64'd0), {1'b0, 64'h3322});
        check("model_lh_strict", model(1, 2, 1, 64'h4433_2211, 64'd0, 64'd0), {1'b1, 64'd0});

        issue(0, 0, 2, 64'h12F4_5678, 64'd0, 64'd0, got);
        check("lb_sign", got, {1'b0, 64'h0000_0000_FFFF_FFF4});
        issue(0, 1, 2, 64'h12F4_5678, 64'd0, 64'd0, got);
        check("lbu_zero", got, {1'b0, 64'h0000_0000_0000_00F4});
        issue(0, 7, 1, 64'hAABB_CCDD, 64'd0, 64'h1122_3344, got);
        check("lwl_off1", got, {1'b0, 64'h0000_0000_CCDD_3344});
        issue(0, 8, 1, 64'hAABB_CCDD, 64'd0, 64'h1122_3344, got);
        check("lwr_off1", got, {1'b0, 64'h0000_0000_11AA_BBCC});
        issue(0, 4, 3, 64'h4433_2211, 64'h8877_6655, 64'd0, got);
        check("lw_split", got, {1'b0, 64'h0000_0000_7766_5544});
        issue(1, 4, 3, 64'h4433_2211, 64'h8877_6655, 64'd0, got);
        check("lw_strict_adel", got, {1'b1, 64'd0});
        issue(2, 6, 0, 64'h8000_0000_0000_0001, 64'd0, 64'd0, got);
        check("ld_full", got, {1'b0, 64'h8000_0000_0000_0001});
        issue(2, 2, 6, 64'h8001_0000_0000_0000, 64'd0, 64'd0, got);
        check("lh64_off6", got, {1'b0, 64'hFFFF_FFFF_FFFF_8001});
        issue(0, 5, 0, 64'h1234_5678, 64'd0, 64'd0, got);
        check("lwu32_adel", got, {1'b1, 64'd0});
        issue(2, 9, 0, 64'h1234_5678, 64'd0, 64'd0, got);
        check("type9_adel", got, {1'b1, 64'd0});

        out_ready = 1'b0;
        issue(0, 4, 0, 64'h1357_9BDF, 64'd0, 64'd0, got);
        check("bp_first", got, {1'b0, 64'h1357_9BDF});
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {64'd0, rdy[0]}, 65'd0);
            check("bp_data", {ad0, 32'd0, od0}, {1'b0, 64'h1357_9BDF});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(0, 4, 0, 64'h2468_ACE0, 64'd0, 64'd0, got);
        check("bp_no_bubble", got, {1'b0, 64'h2468_ACE0});

        beat(0, 4, 3, 64'h4433_2211, 64'd0);
        check("flush_wait2", {64'd0, nb2[0]}, 65'd1);
        in_data = 64'h8877_6655;
        flush   = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        vi[0] = 1'b0;
        check("flush_need_beat2", {64'd0, nb2[0]}, 65'd0);
        check("flush_valid", {64'd0, ov[0]}, 65'd0);
        issue(0, 4, 0, 64'hCAFE_F00D, 64'd0, 64'd0, got);
        check("after_flush_lw", got, {1'b0, 64'hCAFE_F00D});

        beat(2, 6, 4, 64'h1122_3344_5566_7788, 64'd0);
        check("rst_wait2", {64'd0, nb2[2]}, 65'd1);
        vi[2] = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst2_need_beat2", {64'd0, nb2[2]}, 65'd0);
        check("rst2_valid", {64'd0, ov[2]}, 65'd0);
        issue(2, 6, 0, 64'h0123_4567_89AB_CDEF, 64'd0, 64'd0, got);
        check("after_rst_ld", got, {1'b0, 64'h0123_4567_89AB_CDEF});

        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 10; t++) begin
                for (int off = 0; off < ((k == 2) ? 8 : 4); off++) begin
                    issue(k, t, off, pat[(t + off) % 4], pat[(t + off + 1) % 4], pat[(t + 2*off + 3) % 4], got);
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("q0_drained", 65'(q0.size()), 65'd0);
        check("q1_drained", 65'(q1.size()), 65'd0);
        check("q2_drained", 65'(q2.size()), 65'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
